// File: rtl/iguana_uart_sink.sv
// UART receive sink: 2-FF synchronized 8-bit receiver feeding a small FIFO.
// Define IGUANA_UART_SINK_PARITY_EN for 8E1 frames; default build receives 8N1.
module iguana_uart_sink #(
    parameter int unsigned ClksPerBit = 16,
    parameter int unsigned FifoDepth  = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           uart_rx_i,
    output logic [7:0]                     data_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic                           busy_o,
    output logic [$clog2(FifoDepth+1)-1:0] fill_o,
    output logic                           frame_err_o,
    output logic                           parity_err_o,
    output logic                           overflow_o
);
    localparam int unsigned CntW  = $clog2(ClksPerBit);
    localparam int unsigned PtrW  = $clog2(FifoDepth);
    localparam int unsigned FillW = $clog2(FifoDepth + 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(ClksPerBit / 2);
    localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e            r_state, w_state_n;
    logic              r_sync1, r_sync2, r_rx_q;
    logic [CntW-1:0]   r_cnt, w_cnt_n;
    logic [2:0]        r_bit_idx, w_bit_idx_n;
    logic [7:0]        r_shift, w_shift_n;
    logic              w_fall, w_stop_smp, w_par_ok;
    logic              w_push, w_frame_err;
`ifdef IGUANA_UART_SINK_PARITY_EN
    logic              r_par_bit, w_par_bit_n;
    logic              w_par_err, r_parity_err;
`endif

    logic [7:0]        r_mem [FifoDepth];
    logic [PtrW-1:0]   r_wr_ptr, r_rd_ptr, w_rd_ptr_n;
    logic [FillW-1:0]  r_fill, w_fill_n;
    logic              r_valid, r_busy, r_frame_err, r_overflow;
    logic [7:0]        r_data, w_head_n;
    logic              w_pop, w_full, w_wr_en, w_ovf;

    assign w_fall = r_rx_q & ~r_sync2;

    // Receiver next-state: half-bit start qualification, then one sample per bit time
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt + CntW'(1);
        w_bit_idx_n = r_bit_idx;
        w_shift_n   = r_shift;
        w_stop_smp  = 1'b0;
`ifdef IGUANA_UART_SINK_PARITY_EN
        w_par_bit_n = r_par_bit;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                if (w_fall) w_state_n = S_START;
            end
            S_START: begin
                if (r_cnt == CntHalf) begin
                    w_cnt_n     = '0;
                    w_bit_idx_n = '0;
                    w_state_n   = r_sync2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == CntLast) begin
                    w_cnt_n     = '0;
                    w_shift_n   = {r_sync2, r_shift[7:1]};
                    w_bit_idx_n = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef IGUANA_UART_SINK_PARITY_EN
                        w_state_n = S_PARITY;
`else
                        w_state_n = S_STOP;
`endif
                    end
                end
            end
            S_PARITY: begin
                if (r_cnt == CntLast) begin
                    w_cnt_n   = '0;
                    w_state_n = S_STOP;
`ifdef IGUANA_UART_SINK_PARITY_EN
                    w_par_bit_n = r_sync2;
`endif
                end
            end
            S_STOP: begin
                if (r_cnt == CntLast) begin
                    w_cnt_n    = '0;
                    w_stop_smp = 1'b1;
                    w_state_n  = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

`ifdef IGUANA_UART_SINK_PARITY_EN
    assign w_par_ok  = ((^r_shift) == r_par_bit);
    assign w_par_err = w_stop_smp & r_sync2 & ~w_par_ok;
`else
    assign w_par_ok  = 1'b1;
`endif
    // A low stop bit wins over any parity result
    assign w_frame_err = w_stop_smp & ~r_sync2;
    assign w_push      = w_stop_smp & r_sync2 & w_par_ok;

    // FIFO bookkeeping; the registered head is looked up from next-cycle pointers
    always_comb begin
        w_pop    = r_valid & ready_i;
        w_full   = (r_fill == FillW'(FifoDepth));
        w_wr_en  = w_push & (~w_full | w_pop);
        w_ovf    = w_push & w_full & ~w_pop;
        w_fill_n = r_fill;
        if (w_wr_en && !w_pop) begin
            w_fill_n = r_fill + FillW'(1);
        end else if (!w_wr_en && w_pop) begin
            w_fill_n = r_fill - FillW'(1);
        end
        w_rd_ptr_n = w_pop ? r_rd_ptr + PtrW'(1) : r_rd_ptr;
        w_head_n   = (w_wr_en && (r_wr_ptr == w_rd_ptr_n)) ? r_shift : r_mem[w_rd_ptr_n];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_rx_q      <= 1'b1;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_sync1     <= uart_rx_i;
            r_sync2     <= r_sync1;
            r_rx_q      <= r_sync2;
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_bit_idx   <= w_bit_idx_n;
            r_shift     <= w_shift_n;
            r_wr_ptr    <= w_wr_en ? r_wr_ptr + PtrW'(1) : r_wr_ptr;
            r_rd_ptr    <= w_rd_ptr_n;
            r_fill      <= w_fill_n;
            r_valid     <= (w_fill_n != '0);
            r_data      <= (w_fill_n != '0) ? w_head_n : 8'h00;
            r_busy      <= (w_state_n != S_IDLE);
            r_frame_err <= w_frame_err;
            r_overflow  <= w_ovf;
        end
    end

`ifdef IGUANA_UART_SINK_PARITY_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_par_bit    <= w_par_bit_n;
            r_parity_err <= w_par_err;
        end
    end
    assign parity_err_o = r_parity_err;
`else
    assign parity_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_ni && w_wr_en) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign busy_o      = r_busy;
    assign fill_o      = r_fill;
    assign frame_err_o = r_frame_err;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_iguana_uart_sink.sv
// Bench for iguana_uart_sink: frame-level model (byte queue + timed outcome events)
// checked against the DUT every cycle, plus literal spot checks.
module tb_iguana_uart_sink;
    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 4;
`ifdef IGUANA_UART_SINK_PARITY_EN
    localparam int unsigned PBITS = 1;
`else
    localparam int unsigned PBITS = 0;
`endif
    localparam int unsigned FW = $clog2(DEPTH + 1);
    // Edges from driving the start bit to the stop-sample edge: two sync stages plus
    // edge detect, half-bit start check, then one bit time per data/parity/stop bit.
    localparam int unsigned LAT = 3 + CPB / 2 + 1 + CPB * (8 + PBITS + 1);

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          uart_rx_i;
    logic [7:0]    data_o;
    logic          valid_o;
    logic          ready_i;
    logic          busy_o;
    logic [FW-1:0] fill_o;
    logic          frame_err_o;
    logic          parity_err_o;
    logic          overflow_o;

    iguana_uart_sink #(.ClksPerBit(CPB), .FifoDepth(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .uart_rx_i    (uart_rx_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .busy_o       (busy_o),
        .fill_o       (fill_o),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef enum int {EV_BUSY_ON, EV_BUSY_OFF, EV_GOOD, EV_FERR, EV_PERR} ev_kind_e;
    typedef struct {
        int unsigned at;
        ev_kind_e    kind;
        logic [7:0]  b;
    } ev_t;

    ev_t         evq[$];
    logic [7:0]  mq[$];
    logic [7:0]  popped[$];
    bit          e_busy = 1'b0, e_ferr = 1'b0, e_perr = 1'b0, e_ovf = 1'b0;
    int unsigned cyc = 0;
    int          n_vec = 0, n_fail = 0;
    int          ovf_seen = 0, ferr_seen = 0, perr_seen = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void add_ev(input int unsigned at, input ev_kind_e k, input logic [7:0] b);
        ev_t e;
        e.at   = at;
        e.kind = k;
        e.b    = b;
        evq.push_back(e);
    endfunction

    // Model: pop on valid&&ready, then apply any frame outcome due on this edge
    always @(posedge clk_i) begin
        logic [7:0] tmp;
        cyc = cyc + 1;
        e_ferr = 1'b0;
        e_perr = 1'b0;
        e_ovf  = 1'b0;
        if (!rst_ni) begin
            mq.delete();
            evq.delete();
            e_busy = 1'b0;
        end else begin
            if (valid_o && ready_i) popped.push_back(data_o);
            if (mq.size() != 0 && ready_i) tmp = mq.pop_front();
            for (int i = int'(evq.size()) - 1; i >= 0; i--) begin
                if (evq[i].at == cyc) begin
                    case (evq[i].kind)
                        EV_BUSY_ON:  e_busy = 1'b1;
                        EV_BUSY_OFF: e_busy = 1'b0;
                        EV_FERR:     e_ferr = 1'b1;
                        EV_PERR:     e_perr = 1'b1;
                        EV_GOOD: begin
                            if (mq.size() < DEPTH) mq.push_back(evq[i].b);
                            else e_ovf = 1'b1;
                        end
                        default: ;
                    endcase
                    evq.delete(i);
                end
            end
        end
    end

    // Compare every output against the model on the falling edge
    always @(negedge clk_i) begin
        if (cyc != 0) begin
            chk("valid", 32'(valid_o), 32'(mq.size() != 0));
            chk("data", 32'(data_o), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
            chk("fill", 32'(fill_o), 32'(mq.size()));
            chk("busy", 32'(busy_o), 32'(e_busy));
            chk("frame_err", 32'(frame_err_o), 32'(e_ferr));
            chk("parity_err", 32'(parity_err_o), 32'(e_perr));
            chk("overflow", 32'(overflow_o), 32'(e_ovf));
            if (frame_err_o) ferr_seen++;
            if (parity_err_o) perr_seen++;
            if (overflow_o) ovf_seen++;
        end
    end

    task automatic bit_time();
        repeat (CPB) @(negedge clk_i);
    endtask

    // Drive one frame from a negedge and schedule its expected outcome
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_flip,
                              input int unsigned extra_low);
        int unsigned c0 = cyc;
        add_ev(c0 + 3, EV_BUSY_ON, 8'h00);
        add_ev(c0 + LAT, EV_BUSY_OFF, 8'h00);
        if (!stop_ok) add_ev(c0 + LAT, EV_FERR, 8'h00);
        else if (PBITS != 0 && par_flip) add_ev(c0 + LAT, EV_PERR, 8'h00);
        else add_ev(c0 + LAT, EV_GOOD, b);
        uart_rx_i = 1'b0;
        bit_time();
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            bit_time();
        end
`ifdef IGUANA_UART_SINK_PARITY_EN
        uart_rx_i = (^b) ^ par_flip;
        bit_time();
`endif
        uart_rx_i = stop_ok;
        bit_time();
        repeat (extra_low) @(negedge clk_i);
        uart_rx_i = 1'b1;
        repeat (4) @(negedge clk_i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int unsigned c0;
        rst_ni    = 1'b0;
        uart_rx_i = 1'b1;
        ready_i   = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_fill", 32'(fill_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk_i);

        send_frame(8'hA5, 1'b1, 1'b0, 0);
        chk("a5_data", 32'(data_o), 32'hA5);
        chk("a5_fill", 32'(fill_o), 32'h1);
        chk("a5_valid", 32'(valid_o), 32'h1);
        chk("a5_noerr", 32'(ferr_seen + perr_seen + ovf_seen), 32'h0);
        ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        ready_i = 1'b0;
        chk("a5_drained", 32'(fill_o), 32'h0);

        f0 = ferr_seen;
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        chk("3c_ferr", 32'(ferr_seen - f0), 32'h1);
        chk("3c_fill", 32'(fill_o), 32'h0);

`ifdef IGUANA_UART_SINK_PARITY_EN
        f0 = perr_seen;
        send_frame(8'h07, 1'b1, 1'b1, 0);
        chk("07_perr", 32'(perr_seen - f0), 32'h1);
        chk("07_nopush", 32'(fill_o), 32'h0);
        send_frame(8'h07, 1'b1, 1'b0, 0);
        chk("07_data", 32'(data_o), 32'h07);
        ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        ready_i = 1'b0;
`endif

        f0 = ovf_seen;
        for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1, 1'b0, 0);
        chk("ovf_fill", 32'(fill_o), 32'h4);
        chk("ovf_pulses", 32'(ovf_seen - f0), 32'h1);
        chk("ovf_head", 32'(data_o), 32'h01);
        popped.delete();
        ready_i = 1'b1;
        repeat (6) @(negedge clk_i);
        ready_i = 1'b0;
        chk("drain_count", 32'(popped.size()), 32'h4);
        for (int i = 0; i < 4 && i < popped.size(); i++) chk("drain_order", 32'(popped[i]), 32'(i + 1));

        ready_i = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b0, 0);
        send_frame(8'hC3, 1'b1, 1'b0, 0);
        send_frame(8'h00, 1'b1, 1'b0, 0);
        send_frame(8'hFF, 1'b1, 1'b0, 0);
        ready_i = 1'b0;
        chk("b2b_fill", 32'(fill_o), 32'h0);

        // Short low glitch: start check at half bit sees the line high again
        c0 = cyc;
        add_ev(c0 + 3, EV_BUSY_ON, 8'h00);
        add_ev(c0 + 3 + CPB / 2 + 1, EV_BUSY_OFF, 8'h00);
        f0 = ferr_seen;
        uart_rx_i = 1'b0;
        repeat (4) @(negedge clk_i);
        uart_rx_i = 1'b1;
        repeat (20) @(negedge clk_i);
        chk("glitch_busy", 32'(busy_o), 32'h0);
        chk("glitch_fill", 32'(fill_o), 32'h0);
        chk("glitch_noerr", 32'(ferr_seen - f0), 32'h0);

        f0 = ferr_seen;
        send_frame(8'h00, 1'b0, 1'b0, 100);
        chk("break_ferr", 32'(ferr_seen - f0), 32'h1);
        send_frame(8'h81, 1'b1, 1'b0, 0);
        chk("81_data", 32'(data_o), 32'h81);

        // Reset during data bit 3 of 0xFF, with a byte still queued
        c0 = cyc;
        add_ev(c0 + 3, EV_BUSY_ON, 8'h00);
        uart_rx_i = 1'b0;
        bit_time();
        uart_rx_i = 1'b1;
        repeat (3 * CPB + CPB / 2) @(negedge clk_i);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("mid_rst_data", 32'(data_o), 32'h0);
        chk("mid_rst_valid", 32'(valid_o), 32'h0);
        chk("mid_rst_fill", 32'(fill_o), 32'h0);
        chk("mid_rst_busy", 32'(busy_o), 32'h0);
        rst_ni = 1'b1;
        repeat (10) @(negedge clk_i);
        send_frame(8'h12, 1'b1, 1'b0, 0);
        chk("12_data", 32'(data_o), 32'h12);
        chk("12_fill", 32'(fill_o), 32'h1);
        ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        ready_i = 1'b0;
        repeat (3) @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
